exec_stage: RTL and testbench

Multi-cycle execute/writeback stage that sits directly upstream and downstream of the combinational `alu`. It accepts one decoded instruction at a time over a valid/ready handshake and reads its operands from a 4x8 register file. It drives the ALU operand and opcode inputs, captures the ALU result and carry/overflow, then writes the result back and updates the Z/N/C/V flag register.

---
 rtl/cpu_pkg.sv | 49 ++++
 rtl/regfile_4x8.sv | 47 ++++
 rtl/exec_stage.sv | 195 +++++++++++++++++++
 tb/tb_exec_stage.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the execute/writeback stage and its register file:
//   - ALU opcode constants OP_ADD..OP_ROR (0x00-0x0C), OP_LDI (0x80),
//     OP_MAX_ALU (highest legal ALU opcode)
//   - exec_stage FSM state encoding
//   - bit positions of the Z/N/C/V flags inside the 4-bit flag register
//   - opcode classification helpers
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [7:0] OP_ADD     = 8'h00;
    localparam logic [7:0] OP_SUB     = 8'h01;
    localparam logic [7:0] OP_AND     = 8'h02;
    localparam logic [7:0] OP_OR      = 8'h03;
    localparam logic [7:0] OP_XOR     = 8'h04;
    localparam logic [7:0] OP_NOT     = 8'h05;
    localparam logic [7:0] OP_SHL     = 8'h06;
    localparam logic [7:0] OP_SHR     = 8'h07;
    localparam logic [7:0] OP_SAR     = 8'h08;
    localparam logic [7:0] OP_INC     = 8'h09;
    localparam logic [7:0] OP_DEC     = 8'h0A;
    localparam logic [7:0] OP_ROL     = 8'h0B;
    localparam logic [7:0] OP_ROR     = 8'h0C;
    localparam logic [7:0] OP_MAX_ALU = 8'h0C;
    localparam logic [7:0] OP_LDI     = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_EX   = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    // flags = {Z,N,C,V}
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic is_alu_op(input logic [7:0] op);
        return op <= OP_MAX_ALU;
    endfunction

    function automatic logic is_ldi_op(input logic [7:0] op);
        return op == OP_LDI;
    endfunction

endpackage

// File: rtl/regfile_4x8.sv
// -----------------------------------------------------------------------------
// regfile_4x8
// Four 8-bit registers with two combinational operand read ports, one
// combinational debug read port and one synchronous write port. A write is
// visible on the read ports only after the clock edge that performs it.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset (clears to 0)
//   we, waddr, wdata     write enable / address / data
//   ra_sel, ra_data      operand A read port
//   rb_sel, rb_data      operand B read port
//   dbg_sel, dbg_data    debug read port
// -----------------------------------------------------------------------------
module regfile_4x8
    import cpu_pkg::*;
#(
    parameter int NREGS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [1:0] waddr,
    input  logic [7:0] wdata,
    input  logic [1:0] ra_sel,
    output logic [7:0] ra_data,
    input  logic [1:0] rb_sel,
    output logic [7:0] rb_data,
    input  logic [1:0] dbg_sel,
    output logic [7:0] dbg_data
);

    logic [7:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign ra_data  = regs[ra_sel];
    assign rb_data  = regs[rb_sel];
    assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/exec_stage.sv
// -----------------------------------------------------------------------------
// exec_stage
// Multi-cycle execute/writeback stage wrapped around an external
// combinational ALU. One instruction is accepted at a time; it walks
// IDLE -> RD -> EX -> WB (ALU ops), IDLE -> RD -> WB (LDI) or
// IDLE -> RD -> IDLE (illegal opcode).
//
// Build option: define EXEC_ILLEGAL_TRAP_EN to make an illegal opcode set a
// sticky `illegal` flag and park the stage (in_ready=0) until reset. Without
// it an illegal opcode is a NOP and `illegal` pulses for one cycle.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready               instruction handshake
//   in_op, in_rd, in_rs, in_imm     decoded instruction
//   alu_a, alu_b, alu_op            ALU operands/opcode (non-zero only in EX)
//   alu_result, alu_c, alu_v        ALU result, carry, overflow
//   wb_valid, wb_rd, wb_data        register write pulse, address, data
//   flags                           {Z,N,C,V}
//   illegal                         illegal opcode indication
//   dbg_sel, dbg_data               combinational debug register read
// -----------------------------------------------------------------------------
module exec_stage
    import cpu_pkg::*;
#(
    parameter int NREGS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_op,
    input  logic [1:0] in_rd,
    input  logic [1:0] in_rs,
    input  logic [7:0] in_imm,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [7:0] alu_op,
    input  logic [7:0] alu_result,
    input  logic       alu_c,
    input  logic       alu_v,
    output logic       wb_valid,
    output logic [1:0] wb_rd,
    output logic [7:0] wb_data,
    output logic [3:0] flags,
    output logic       illegal,
    input  logic [1:0] dbg_sel,
    output logic [7:0] dbg_data
);

    state_t     state, state_nxt;

    logic [7:0] op_p0;
    logic [1:0] rd_p0;
    logic [1:0] rs_p0;
    logic [7:0] imm_p0;
    logic [7:0] a_p1;
    logic [7:0] b_p1;
    logic [7:0] res_p2;
    logic       c_p2;
    logic       v_p2;

    logic [3:0] flags_q;
    logic [3:0] flags_wb;
    logic       illegal_q;
    logic       ready_idle;
    logic       accept;
    logic       illegal_in_rd;
    logic [7:0] rf_a;
    logic [7:0] rf_b;

    regfile_4x8 #(
        .NREGS(NREGS)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wb_valid),
        .waddr   (wb_rd),
        .wdata   (wb_data),
        .ra_sel  (rd_p0),
        .ra_data (rf_a),
        .rb_sel  (rs_p0),
        .rb_data (rf_b),
        .dbg_sel (dbg_sel),
        .dbg_data(dbg_data)
    );

`ifdef EXEC_ILLEGAL_TRAP_EN
    // Once an illegal opcode has been seen the stage stops accepting work.
    assign ready_idle = ~illegal_q;
`else
    assign ready_idle = 1'b1;
`endif

    assign accept        = (state == ST_IDLE) && ready_idle && in_valid;
    assign illegal_in_rd = (state == ST_RD) && !is_alu_op(op_p0) && !is_ldi_op(op_p0);

    // Data path registers carry no reset: the FSM state alone decides when
    // they are looked at, so stale contents are never observable.
    always_ff @(posedge clk) begin
        // p0: instruction captured at acceptance
        if (accept) begin
            op_p0  <= in_op;
            rd_p0  <= in_rd;
            rs_p0  <= in_rs;
            imm_p0 <= in_imm;
        end
        // p1: operands read in RD
        if (state == ST_RD) begin
            a_p1 <= rf_a;
            b_p1 <= rf_b;
        end
        // p2: ALU response captured in EX
        if (state == ST_EX) begin
            res_p2 <= alu_result;
            c_p2   <= alu_c;
            v_p2   <= alu_v;
        end
    end

    always_comb begin
        flags_wb         = '0;
        flags_wb[FLAG_Z] = (res_p2 == 8'h00);
        flags_wb[FLAG_N] = res_p2[7];
        flags_wb[FLAG_C] = c_p2;
        flags_wb[FLAG_V] = v_p2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            flags_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == ST_WB) && is_alu_op(op_p0)) begin
                flags_q <= flags_wb;
            end
`ifdef EXEC_ILLEGAL_TRAP_EN
            if (illegal_in_rd) begin
                illegal_q <= 1'b1;
            end
`else
            illegal_q <= illegal_in_rd;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = '0;
        wb_valid  = 1'b0;
        wb_rd     = '0;
        wb_data   = '0;
        case (state)
            ST_IDLE: begin
                in_ready = ready_idle;
                if (accept) begin
                    state_nxt = ST_RD;
                end
            end
            ST_RD: begin
                if (is_alu_op(op_p0)) begin
                    state_nxt = ST_EX;
                end else if (is_ldi_op(op_p0)) begin
                    state_nxt = ST_WB;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_EX: begin
                alu_a     = a_p1;
                alu_b     = b_p1;
                alu_op    = op_p0;
                state_nxt = ST_WB;
            end
            ST_WB: begin
                wb_valid  = 1'b1;
                wb_rd     = rd_p0;
                wb_data   = is_alu_op(op_p0) ? res_p2 : imm_p0;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign flags   = flags_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_exec_stage.sv
// -----------------------------------------------------------------------------
// tb_exec_stage
// Self-checking bench for exec_stage. A behavioural ALU drives the DUT's ALU
// inputs; a reference model (register array + flags) predicts every register
// write, which is queued at acceptance and compared by an independent monitor
// whenever wb_valid is seen.
// -----------------------------------------------------------------------------
module tb_exec_stage;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_op = '0;
    logic [1:0] in_rd = '0;
    logic [1:0] in_rs = '0;
    logic [7:0] in_imm = '0;
    logic [7:0] alu_a, alu_b, alu_op, alu_result;
    logic       alu_c, alu_v;
    logic       wb_valid;
    logic [1:0] wb_rd;
    logic [7:0] wb_data;
    logic [3:0] flags;
    logic       illegal;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;

    logic       dbg_force = 1'b0;
    logic [1:0] dbg_force_sel = '0;
    logic [1:0] mon_sel = '0;
    assign dbg_sel = dbg_force ? dbg_force_sel : mon_sel;

    exec_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs     (in_rs),
        .in_imm    (in_imm),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_result(alu_result),
        .alu_c     (alu_c),
        .alu_v     (alu_v),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .flags     (flags),
        .illegal   (illegal),
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: returns {C, V, result}.
    function automatic logic [9:0] ref_alu(input logic [7:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] r;
        logic       c;
        logic       v;
        s = '0;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            8'h00: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[7:0];
                c = s[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            8'h01: begin
                r = a - b;
                c = (a < b);
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            8'h02: r = a & b;
            8'h03: r = a | b;
            8'h04: r = a ^ b;
            8'h05: r = ~a;
            8'h06: r = {a[6:0], 1'b0};
            8'h07: r = {1'b0, a[7:1]};
            8'h08: r = {a[7], a[7:1]};
            8'h09: begin r = a + 8'd1; c = (a == 8'hFF); v = (a == 8'h7F); end
            8'h0A: begin r = a - 8'd1; c = (a == 8'h00); v = (a == 8'h80); end
            8'h0B: r = {a[6:0], a[7]};
            8'h0C: r = {a[0], a[7:1]};
            default: r = '0;
        endcase
        return {c, v, r};
    endfunction

    always_comb {alu_c, alu_v, alu_result} = ref_alu(alu_op, alu_a, alu_b);

    typedef struct {
        logic [1:0] rd;
        logic [7:0] data;
        logic [7:0] old;
        logic [3:0] flg;
        int         wcyc;
    } exp_t;

    exp_t       q[$];
    logic [7:0] mregs[4];
    logic [3:0] mflags;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mregs[i] = '0;
        mflags = '0;
        q.delete();
    endtask

    task automatic check_regs(input string tag);
        dbg_force = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dbg_force_sel = 2'(i);
            #1;
            chk(tag, {24'd0, dbg_data}, {24'd0, mregs[i]});
        end
        dbg_force = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] sel, input logic [7:0] val);
        dbg_force     = 1'b1;
        dbg_force_sel = sel;
        #1;
        chk(tag, {24'd0, dbg_data}, {24'd0, val});
        dbg_force = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready && q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: in_ready=%0b pending=%0d", in_ready, q.size());
        end
    endtask

    // Called at a negedge. Offers one instruction, waits for acceptance and
    // returns at the negedge of the RD cycle with acc = RD cycle number.
    // With garbage set, in_valid stays high and the other inputs are
    // scrambled every cycle the stage is busy.
    task automatic issue(input logic [7:0] op, input logic [1:0] rd, input logic [1:0] rs,
                         input logic [7:0] imm, input bit garbage, output int acc);
        int         waitc;
        exp_t       e;
        logic [9:0] r;
        waitc = 0;
        acc   = -1;
        while (!in_ready && waitc < 20) begin
            if (garbage) begin
                in_valid = 1'b1;
                in_op    = 8'($urandom);
                in_rd    = 2'($urandom);
                in_rs    = 2'($urandom);
                in_imm   = 8'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stuck low for op %0h", op);
            in_valid = 1'b0;
            return;
        end
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = rd;
        in_rs    = rs;
        in_imm   = imm;
        @(posedge clk);
        #1;
        acc = cyc;
        if (garbage) begin
            in_op  = 8'($urandom);
            in_rd  = 2'($urandom);
            in_rs  = 2'($urandom);
            in_imm = 8'($urandom);
        end else begin
            in_valid = 1'b0;
        end
        if (op <= 8'h0C) begin
            r      = ref_alu(op, mregs[rd], mregs[rs]);
            e.rd   = rd;
            e.data = r[7:0];
            e.old  = mregs[rd];
            e.flg  = {(r[7:0] == 8'h00), r[7], r[9], r[8]};
            e.wcyc = acc + 2;
            mregs[rd] = r[7:0];
            mflags    = e.flg;
            q.push_back(e);
        end else if (op == 8'h80) begin
            e.rd   = rd;
            e.data = imm;
            e.old  = mregs[rd];
            e.flg  = mflags;
            e.wcyc = acc + 1;
            mregs[rd] = imm;
            q.push_back(e);
        end
        @(negedge clk);
        chk("ready_low_in_rd", {31'd0, in_ready}, 32'd0);
    endtask

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && in_ready) begin
                chk("idle_outputs_zero", {7'd0, alu_a, alu_b, alu_op, wb_valid}, 32'd0);
            end
            if (rst_n && wb_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wb: rd=%0d data=%0h", wb_rd, wb_data);
                end else begin
                    e       = q.pop_front();
                    mon_sel = e.rd;
                    #1;
                    chk("wb_rd", {30'd0, wb_rd}, {30'd0, e.rd});
                    chk("wb_data", {24'd0, wb_data}, {24'd0, e.data});
                    chk("wb_cycle", cyc, e.wcyc);
                    chk("reg_before_edge", {24'd0, dbg_data}, {24'd0, e.old});
                    @(posedge clk);
                    #1;
                    chk("reg_after_wb", {24'd0, dbg_data}, {24'd0, e.data});
                    chk("flags_after_wb", {28'd0, flags}, {28'd0, e.flg});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         k;
        int         prev_k;
        int         prev_lat;
        logic [7:0] op;
        model_reset();

        // Reset state
        #22;
        chk("rst_flags", {28'd0, flags}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_alu_out", {8'd0, alu_a, alu_b, alu_op}, 32'd0);
        check_regs("rst_regs");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD with signed overflow
        issue(8'h80, 2'd1, 2'd0, 8'h7F, 1'b0, k);
        issue(8'h80, 2'd2, 2'd0, 8'h01, 1'b0, k);
        issue(8'h00, 2'd1, 2'd2, 8'h00, 1'b0, k);
        wait_idle();
        check_reg("add_r1", 2'd1, 8'h80);
        chk("add_flags", {28'd0, flags}, 32'h5);

        // SUB with rd == rs
        issue(8'h80, 2'd0, 2'd0, 8'h05, 1'b0, k);
        issue(8'h01, 2'd0, 2'd0, 8'h00, 1'b0, k);
        wait_idle();
        check_reg("sub_r0", 2'd0, 8'h00);
        chk("sub_flags", {28'd0, flags}, 32'h8);

        // LDI keeps flags, then ROR
        issue(8'h80, 2'd3, 2'd0, 8'h81, 1'b0, k);
        wait_idle();
        chk("ldi_keeps_flags", {28'd0, flags}, 32'h8);
        issue(8'h0C, 2'd3, 2'd3, 8'h00, 1'b0, k);
        wait_idle();
        check_reg("ror_r3", 2'd3, 8'hC0);
        chk("ror_flags", {28'd0, flags}, 32'h4);

        // Back-to-back with in_valid held high and scrambled inputs while busy
        prev_k   = -1;
        prev_lat = 0;
        for (int n = 0; n < 30; n++) begin
            op = ($urandom_range(0, 13) == 13) ? 8'h80 : 8'($urandom_range(0, 12));
            issue(op, 2'($urandom), 2'($urandom), 8'($urandom), 1'b1, k);
            if (prev_k >= 0) chk("accept_spacing", k - prev_k, prev_lat);
            prev_k   = k;
            prev_lat = (op == 8'h80) ? 3 : 4;
        end
        in_valid = 1'b0;
        wait_idle();
        check_regs("regs_after_burst");

        // Random instructions with idle gaps
        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            op = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom_range(0, 12));
            issue(op, 2'($urandom), 2'($urandom), 8'($urandom), 1'b0, k);
        end
        wait_idle();
        check_regs("regs_after_random");
        chk("flags_after_random", {28'd0, flags}, {28'd0, mflags});

        // Illegal opcode
        issue(8'h0D, 2'd1, 2'd2, 8'h55, 1'b0, k);
        chk("illegal_low_in_rd", {31'd0, illegal}, 32'd0);
`ifdef EXEC_ILLEGAL_TRAP_EN
        @(negedge clk);
        chk("illegal_set", {31'd0, illegal}, 32'd1);
        chk("trap_not_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        in_op    = 8'h80;
        in_rd    = 2'd2;
        in_imm   = 8'hAA;
        repeat (5) begin
            @(negedge clk);
            chk("illegal_sticky", {31'd0, illegal}, 32'd1);
            chk("trap_parked", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        chk("flags_after_illegal", {28'd0, flags}, {28'd0, mflags});
        check_regs("regs_after_illegal");
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("trap_cleared_by_reset", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_trap_reset", {31'd0, in_ready}, 32'd1);
`else
        @(negedge clk);
        chk("illegal_pulse", {31'd0, illegal}, 32'd1);
        chk("ready_after_illegal", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk("illegal_pulse_end", {31'd0, illegal}, 32'd0);
        chk("flags_after_illegal", {28'd0, flags}, {28'd0, mflags});
        check_regs("regs_after_illegal");
`endif

        // Reset during EX of an ADD
        issue(8'h80, 2'd1, 2'd0, 8'h33, 1'b0, k);
        issue(8'h80, 2'd2, 2'd0, 8'h44, 1'b0, k);
        issue(8'h00, 2'd1, 2'd2, 8'h00, 1'b0, k);
        wait_idle();
        issue(8'h00, 2'd1, 2'd2, 8'h00, 1'b0, k);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("midrst_flags", {28'd0, flags}, 32'd0);
        chk("midrst_alu_out", {8'd0, alu_a, alu_b, alu_op}, 32'd0);
        chk("midrst_illegal", {31'd0, illegal}, 32'd0);
        check_regs("midrst_regs");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_release", {31'd0, in_ready}, 32'd1);
        chk("no_wb_after_release", {31'd0, wb_valid}, 32'd0);

        // Normal operation after reset
        issue(8'h80, 2'd2, 2'd0, 8'h10, 1'b0, k);
        issue(8'h00, 2'd2, 2'd2, 8'h00, 1'b0, k);
        wait_idle();
        check_reg("post_reset_add", 2'd2, 8'h20);

        chk("scoreboard_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
